mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS control unit: the producer side of the ALU operation interface.
- Decodes the instruction held in the IR and steps through IF/ID/EX/MEM/WB.
- Drives the 5-bit ALU operation select plus the datapath strobes (PC, IR, memory, register file).
- Consumes the ALU Zero flag to resolve beq.

Parameters:
- OPW, 5, width of alu_op; matches the ALUOp_* macro width in ctrl_encode_def.v.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- instr  in  32  IR contents; stable from ID until the next IF
- zero  in  1  ALU Zero flag (ALU C[0]); for ALUOp_BEQ, 1 means A==B
- alu_op  out  OPW  ALU operation select, `ALUOp_* encodings
- alu_src_a  out  1  0 = register rs, 1 = zero-extended shamt (instr[10:6])
- alu_src_b  out  1  0 = register rt, 1 = sign-extended imm16
- pc_write  out  1  PC load strobe
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = unused
- ir_write  out  1  IR load strobe
- mem_read  out  1  data memory read strobe
- mem_write  out  1  data memory write strobe
- reg_write  out  1  register file write strobe
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- done  out  1  one-cycle pulse on the last cycle of each legal instruction
- illegal  out  1  one-cycle pulse in ID for an unsupported encoding
- state  out  3  current state (debug): IF=0, ID=1, EX=2, MEM=3, WB=4

Behaviour:
- Supported instructions:
  - R-type (op 0x00): add funct 0x20 -> ALUOp_ADD; subu 0x23 -> ALUOp_SUBU; or 0x25 -> ALUOp_OR; slt 0x2A -> ALUOp_SLT; sll 0x00 -> ALUOp_SLL.
  - I-type and jump: addi op 0x08 -> ALUOp_ADDI; lw 0x23 and sw 0x2B -> ALUOp_ADD; beq 0x04 -> ALUOp_BEQ; j 0x02.
  - Every other op or funct is illegal.
- State register only; all outputs are combinational Moore/Mealy decodes of state, instr and zero. Unlisted outputs are 0 in each state.
- IF: ir_write=1, pc_write=1, pc_src=0. Next state ID.
- ID:
  - j: pc_write=1, pc_src=2, done=1, next IF.
  - illegal: illegal=1, no strobes, next IF.
  - otherwise next EX.
- EX: alu_op=decoded value; alu_src_a=1 only for sll; alu_src_b=1 for addi/lw/sw.
  - beq: pc_write=zero, pc_src=1, done=1, next IF.
  - lw/sw: next MEM.
  - R-type/addi: next WB.
- MEM:
  - lw: mem_read=1, next WB.
  - sw: mem_write=1, done=1, next IF.
- WB: reg_write=1; reg_dst=1 for R-type; mem_to_reg=1 for lw; done=1; next IF.
- alu_op holds the decoded value in EX, MEM and WB; it is 0 in IF and ID.
- Cycle counts per instruction: j 2, beq 3, sw 4, R-type/addi 4, lw 5, illegal 2.
- Reset:
  - rst high at a rising edge forces state to IF.
  - While rst is high, all strobes (pc_write, ir_write, mem_read, mem_write, reg_write, done, illegal) are forced to 0 regardless of state.
  - Reset mid-instruction abandons the instruction with no partial write.
  - After rst deasserts, the first cycle is IF. Post-reset output values: state=0, all strobes 0, alu_op=0.
- Unreachable state codes 5-7 return to IF on the next edge with all outputs 0.
- Instruction 0x00000000 (sll $0,$0,0) is legal: 4 cycles, reg_write asserted to $0.
- zero is sampled only in the EX state of beq and ignored elsewhere.

Test Plan:
- Reset: assert rst for 2 cycles while in EX of an lw -> state=0 and all strobes 0 during rst; first post-reset cycle is IF with ir_write=1, pc_write=1, pc_src=0.
- add $3,$1,$2 (0x00221820) -> states IF,ID,EX,WB.
  - EX: alu_op=ALUOp_ADD, alu_src_b=0.
  - WB: reg_write=1, reg_dst=1, mem_to_reg=0, done=1.
- lw $5,8($4) (0x8C850008) -> 5 cycles; EX alu_src_b=1, alu_op=ALUOp_ADD; MEM mem_read=1; WB reg_write=1, reg_dst=0, mem_to_reg=1.
- beq (0x10220003):
  - zero=1 in EX -> pc_write=1, pc_src=1, done=1.
  - Repeat with zero=0 -> pc_write=0 and next state IF.
- sll $2,$1,4 (0x00011100) -> EX alu_op=ALUOp_SLL, alu_src_a=1. Then j 0x08000010 -> ID pc_write=1, pc_src=2, done=1, 2 cycles total.
- Illegal op 0x3F -> illegal=1 in ID, no write strobes, next IF. Also sw (0xAC850004) -> MEM mem_write=1, done=1, reg_write never asserted.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit.
// Holds only the phase register; every datapath strobe and the ALU operation
// select are decoded combinationally from the phase, the IR and the ALU Zero flag.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IF  0 | fetch: load IR, PC <= PC+4
//   ID  1 | decode: resolve j, flag illegal encodings
//   EX  2 | execute: ALU operates, beq resolves on zero
//   MEM 3 | memory: lw read / sw write
//   WB  4 | write back to register file
//   5-7   | unreachable, recover to IF with all outputs low

module mc_ctrl_fsm #(
  parameter int OPW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    instr_i,
  input  logic           zero_i,
  output logic [OPW-1:0] alu_op_o,
  output logic           alu_src_a_o,
  output logic           alu_src_b_o,
  output logic           pc_write_o,
  output logic [1:0]     pc_src_o,
  output logic           ir_write_o,
  output logic           mem_read_o,
  output logic           mem_write_o,
  output logic           reg_write_o,
  output logic           reg_dst_o,
  output logic           mem_to_reg_o,
  output logic           done_o,
  output logic           illegal_o,
  output logic [2:0]     state_o
);

  // ALU operation encodings shared with the ALU.
  localparam logic [OPW-1:0] ALUOP_NOP  = OPW'(0);
  localparam logic [OPW-1:0] ALUOP_ADD  = OPW'(1);
  localparam logic [OPW-1:0] ALUOP_SUBU = OPW'(2);
  localparam logic [OPW-1:0] ALUOP_OR   = OPW'(3);
  localparam logic [OPW-1:0] ALUOP_SLT  = OPW'(4);
  localparam logic [OPW-1:0] ALUOP_SLL  = OPW'(5);
  localparam logic [OPW-1:0] ALUOP_ADDI = OPW'(6);
  localparam logic [OPW-1:0] ALUOP_BEQ  = OPW'(7);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_J   = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  logic [2:0] state_q, state_d;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       is_rtype, is_sll, is_j, is_beq, is_addi, is_lw, is_sw;
  logic       is_legal;
  logic [OPW-1:0] dec_alu_op;

  assign opcode = instr_i[31:26];
  assign funct  = instr_i[5:0];

  // Instruction class decode; the R-type flag covers only supported functs.
  always_comb begin
    is_rtype   = 1'b0;
    is_sll     = 1'b0;
    dec_alu_op = ALUOP_NOP;
    is_j       = (opcode == OP_J);
    is_beq     = (opcode == OP_BEQ);
    is_addi    = (opcode == OP_ADDI);
    is_lw      = (opcode == OP_LW);
    is_sw      = (opcode == OP_SW);
    if (opcode == OP_RTYPE) begin
      is_rtype = 1'b1;
      case (funct)
        FN_ADD:  dec_alu_op = ALUOP_ADD;
        FN_SUBU: dec_alu_op = ALUOP_SUBU;
        FN_OR:   dec_alu_op = ALUOP_OR;
        FN_SLT:  dec_alu_op = ALUOP_SLT;
        FN_SLL: begin
          dec_alu_op = ALUOP_SLL;
          is_sll     = 1'b1;
        end
        default: is_rtype = 1'b0;
      endcase
    end else if (is_addi) begin
      dec_alu_op = ALUOP_ADDI;
    end else if (is_lw || is_sw) begin
      dec_alu_op = ALUOP_ADD;
    end else if (is_beq) begin
      dec_alu_op = ALUOP_BEQ;
    end
    is_legal = is_rtype || is_j || is_beq || is_addi || is_lw || is_sw;
  end

  // Phase register with synchronous reset back to fetch.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // Next-phase selection.
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (!is_legal || is_j) state_d = S_IF;
        else                   state_d = S_EX;
      end
      S_EX: begin
        if (is_lw || is_sw)           state_d = S_MEM;
        else if (is_rtype || is_addi) state_d = S_WB;
        else                          state_d = S_IF;
      end
      S_MEM: begin
        if (is_lw) state_d = S_WB;
        else       state_d = S_IF;
      end
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  logic       pc_write_raw, ir_write_raw, mem_read_raw, mem_write_raw;
  logic       reg_write_raw, done_raw, illegal_raw;

  // Per-phase output decode; strobes are gated by reset afterwards.
  always_comb begin
    alu_op_o      = ALUOP_NOP;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = 1'b0;
    pc_src_o      = PC_SRC_SEQ;
    reg_dst_o     = 1'b0;
    mem_to_reg_o  = 1'b0;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    done_raw      = 1'b0;
    illegal_raw   = 1'b0;
    case (state_q)
      S_IF: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        pc_src_o     = PC_SRC_SEQ;
      end
      S_ID: begin
        if (!is_legal) begin
          illegal_raw = 1'b1;
        end else if (is_j) begin
          pc_write_raw = 1'b1;
          pc_src_o     = PC_SRC_J;
          done_raw     = 1'b1;
        end
      end
      S_EX: begin
        alu_op_o    = dec_alu_op;
        alu_src_a_o = is_sll;
        alu_src_b_o = is_addi || is_lw || is_sw;
        if (is_beq) begin
          // Zero only matters here; elsewhere it is ignored.
          pc_write_raw = zero_i;
          pc_src_o     = PC_SRC_BR;
          done_raw     = 1'b1;
        end
      end
      S_MEM: begin
        alu_op_o = dec_alu_op;
        if (is_lw) begin
          mem_read_raw = 1'b1;
        end else if (is_sw) begin
          mem_write_raw = 1'b1;
          done_raw      = 1'b1;
        end
      end
      S_WB: begin
        alu_op_o      = dec_alu_op;
        reg_write_raw = 1'b1;
        reg_dst_o     = is_rtype;
        mem_to_reg_o  = is_lw;
        done_raw      = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset suppresses every strobe so an abandoned instruction writes nothing.
  always_comb begin
    pc_write_o  = pc_write_raw  & ~rst;
    ir_write_o  = ir_write_raw  & ~rst;
    mem_read_o  = mem_read_raw  & ~rst;
    mem_write_o = mem_write_raw & ~rst;
    reg_write_o = reg_write_raw & ~rst;
    done_o      = done_raw      & ~rst;
    illegal_o   = illegal_raw   & ~rst;
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: one table row per clock cycle, plus a
// hand-written reset-in-flight sequence.

module tb_mc_ctrl_fsm;

  localparam int OPW = 5;

  localparam logic [4:0] A_NOP  = 5'd0;
  localparam logic [4:0] A_ADD  = 5'd1;
  localparam logic [4:0] A_SLL  = 5'd5;
  localparam logic [4:0] A_ADDI = 5'd6;
  localparam logic [4:0] A_BEQ  = 5'd7;

  logic           clk = 1'b0;
  logic           rst;
  logic [31:0]    instr;
  logic           zero;
  logic [OPW-1:0] alu_op;
  logic           alu_src_a, alu_src_b, pc_write, ir_write;
  logic [1:0]     pc_src;
  logic           mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
  logic           done, illegal;
  logic [2:0]     state;

  mc_ctrl_fsm #(.OPW(OPW)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_i      (instr),
    .zero_i       (zero),
    .alu_op_o     (alu_op),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .pc_write_o   (pc_write),
    .pc_src_o     (pc_src),
    .ir_write_o   (ir_write),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .reg_write_o  (reg_write),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .done_o       (done),
    .illegal_o    (illegal),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic [2:0]  exp_state;
    logic [17:0] exp_out;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // {alu_op, src_a, src_b, pc_write, pc_src, ir_write, mem_read, mem_write,
  //  reg_write, reg_dst, mem_to_reg, done, illegal}
  function automatic logic [17:0] mk(logic [4:0] op, logic sa, logic sb, logic pw,
                                     logic [1:0] ps, logic irw, logic mr, logic mw,
                                     logic rw, logic rd, logic m2r, logic dn, logic il);
    return {op, sa, sb, pw, ps, irw, mr, mw, rw, rd, m2r, dn, il};
  endfunction

  function automatic logic [17:0] act_out();
    return {alu_op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write, mem_read,
            mem_write, reg_write, reg_dst, mem_to_reg, done, illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, sample on the falling edge.
  task automatic cyc(input logic r, input logic [31:0] ins, input logic z);
    @(posedge clk);
    #1;
    rst   = r;
    instr = ins;
    zero  = z;
    @(negedge clk);
  endtask

  vec_t vecs[$];

  task automatic add_v(input logic [31:0] ins, input logic z, input logic [2:0] st,
                       input logic [17:0] o);
    vec_t v;
    v.rst = 1'b0; v.instr = ins; v.zero = z; v.exp_state = st; v.exp_out = o;
    vecs.push_back(v);
  endtask

  logic [17:0] O_IF, O_ZERO;

  initial begin
    O_IF   = mk(A_NOP,0,0,1,2'd0,1,0,0,0,0,0,0,0);
    O_ZERO = mk(A_NOP,0,0,0,2'd0,0,0,0,0,0,0,0,0);

    // add $3,$1,$2
    add_v(32'h00221820, 0, 3'd0, O_IF);
    add_v(32'h00221820, 0, 3'd1, O_ZERO);
    add_v(32'h00221820, 1, 3'd2, mk(A_ADD,0,0,0,2'd0,0,0,0,0,0,0,0,0));
    add_v(32'h00221820, 0, 3'd4, mk(A_ADD,0,0,0,2'd0,0,0,0,1,1,0,1,0));
    // lw $5,8($4)
    add_v(32'h8C850008, 0, 3'd0, O_IF);
    add_v(32'h8C850008, 0, 3'd1, O_ZERO);
    add_v(32'h8C850008, 0, 3'd2, mk(A_ADD,0,1,0,2'd0,0,0,0,0,0,0,0,0));
    add_v(32'h8C850008, 0, 3'd3, mk(A_ADD,0,0,0,2'd0,0,1,0,0,0,0,0,0));
    add_v(32'h8C850008, 0, 3'd4, mk(A_ADD,0,0,0,2'd0,0,0,0,1,0,1,1,0));
    // beq taken; zero high outside EX must not matter
    add_v(32'h10220003, 1, 3'd0, O_IF);
    add_v(32'h10220003, 1, 3'd1, O_ZERO);
    add_v(32'h10220003, 1, 3'd2, mk(A_BEQ,0,0,1,2'd1,0,0,0,0,0,0,1,0));
    // beq not taken
    add_v(32'h10220003, 0, 3'd0, O_IF);
    add_v(32'h10220003, 0, 3'd1, O_ZERO);
    add_v(32'h10220003, 0, 3'd2, mk(A_BEQ,0,0,0,2'd1,0,0,0,0,0,0,1,0));
    // sll $2,$1,4
    add_v(32'h00011100, 0, 3'd0, O_IF);
    add_v(32'h00011100, 0, 3'd1, O_ZERO);
    add_v(32'h00011100, 0, 3'd2, mk(A_SLL,1,0,0,2'd0,0,0,0,0,0,0,0,0));
    add_v(32'h00011100, 0, 3'd4, mk(A_SLL,0,0,0,2'd0,0,0,0,1,1,0,1,0));
    // j
    add_v(32'h08000010, 0, 3'd0, O_IF);
    add_v(32'h08000010, 0, 3'd1, mk(A_NOP,0,0,1,2'd2,0,0,0,0,0,0,1,0));
    // illegal opcode 0x3F
    add_v(32'hFC000000, 0, 3'd0, O_IF);
    add_v(32'hFC000000, 0, 3'd1, mk(A_NOP,0,0,0,2'd0,0,0,0,0,0,0,0,1));
    // sw $5,4($4)
    add_v(32'hAC850004, 0, 3'd0, O_IF);
    add_v(32'hAC850004, 0, 3'd1, O_ZERO);
    add_v(32'hAC850004, 0, 3'd2, mk(A_ADD,0,1,0,2'd0,0,0,0,0,0,0,0,0));
    add_v(32'hAC850004, 0, 3'd3, mk(A_ADD,0,0,0,2'd0,0,0,1,0,0,0,1,0));
    // all-zero word is sll $0,$0,0
    add_v(32'h00000000, 0, 3'd0, O_IF);
    add_v(32'h00000000, 0, 3'd1, O_ZERO);
    add_v(32'h00000000, 0, 3'd2, mk(A_SLL,1,0,0,2'd0,0,0,0,0,0,0,0,0));
    add_v(32'h00000000, 0, 3'd4, mk(A_SLL,0,0,0,2'd0,0,0,0,1,1,0,1,0));
    // unsupported R-type funct (addu)
    add_v(32'h00221821, 0, 3'd0, O_IF);
    add_v(32'h00221821, 0, 3'd1, mk(A_NOP,0,0,0,2'd0,0,0,0,0,0,0,0,1));
    // addi $1,$1,5
    add_v(32'h20210005, 0, 3'd0, O_IF);
    add_v(32'h20210005, 0, 3'd1, O_ZERO);
    add_v(32'h20210005, 0, 3'd2, mk(A_ADDI,0,1,0,2'd0,0,0,0,0,0,0,0,0));
    add_v(32'h20210005, 0, 3'd4, mk(A_ADDI,0,0,0,2'd0,0,0,0,1,0,0,1,0));

    // Power-on reset for two edges
    rst = 1'b1; instr = 32'h0; zero = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outputs", 32'(act_out()), 32'(O_ZERO));

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].instr, vecs[i].zero);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
      chk($sformatf("vec%0d_outputs", i), 32'(act_out()), 32'(vecs[i].exp_out));
    end

    // Reset arriving during EX of lw: two cycles of rst, then a clean fetch.
    cyc(0, 32'h8C850008, 0);
    chk("rlw_if_state", 32'(state), 32'd0);
    cyc(0, 32'h8C850008, 0);
    chk("rlw_id_state", 32'(state), 32'd1);
    cyc(1, 32'h8C850008, 0);
    chk("rlw_ex_rst_state", 32'(state), 32'd2);
    chk("rlw_ex_rst_outputs", 32'(act_out()), 32'(mk(A_ADD,0,1,0,2'd0,0,0,0,0,0,0,0,0)));
    cyc(1, 32'h8C850008, 0);
    chk("rlw_rst1_state", 32'(state), 32'd0);
    chk("rlw_rst1_outputs", 32'(act_out()), 32'(O_ZERO));
    cyc(0, 32'h8C850008, 0);
    chk("rlw_post_state", 32'(state), 32'd0);
    chk("rlw_post_outputs", 32'(act_out()), 32'(O_IF));
    cyc(0, 32'h8C850008, 0);
    chk("rlw_post_id", 32'(state), 32'd1);
    cyc(0, 32'h8C850008, 0);
    cyc(0, 32'h8C850008, 0);
    chk("rlw2_mem_state", 32'(state), 32'd3);
    // Reset landing in WB must suppress the register write and done.
    cyc(1, 32'h8C850008, 0);
    chk("rlw2_wb_state", 32'(state), 32'd4);
    chk("rlw2_wb_reg_write", 32'(reg_write), 32'd0);
    chk("rlw2_wb_done", 32'(done), 32'd0);
    cyc(0, 32'h00221820, 0);
    chk("rlw2_after_state", 32'(state), 32'd0);
    chk("rlw2_after_outputs", 32'(act_out()), 32'(O_IF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
